// File: rtl/spi_rx_frame.sv
// spi_rx_frame: SPI mode-0 receive framer.
// Synchronises CSN/SCLK/MOSI into clk, shifts MOSI in MSB-first on SCLK rises
// while CSN is low, emits parallel words, counts words per frame, flags frames
// that end mid-word and CSN-high gaps shorter than min_csh.
module spi_rx_frame #(
  parameter int DATA_W = 8,
  parameter int SPI0_2 = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [SPI0_2-1:0] min_csh,
  input  logic              CSN,
  input  logic              SCLK,
  input  logic              MOSI,
  output logic              rx_idle,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              frame_done,
  output logic [15:0]       frame_words,
  output logic              bit_err,
  output logic              csh_err
);

  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_ACT  = 2'b01,
    S_END  = 2'b10
  } state_t;

  state_t state, state_nxt;

  logic csn_s1, csn_s2, csn_s3;
  logic sclk_s1, sclk_s2, sclk_s3;
  logic mosi_s1, mosi_s2;

  logic              csn_fall, csn_rise, sclk_rise;
  logic              start, shift_en, word_done, finish;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shift;
  logic [SPI0_2-1:0] csh_cnt;

  // Two-flop synchronisers plus a history flop for edge detection; idle
  // reset values keep reset release from looking like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csn_s1  <= 1'b1;
      csn_s2  <= 1'b1;
      csn_s3  <= 1'b1;
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      sclk_s3 <= 1'b0;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
    end else begin
      csn_s1  <= CSN;
      csn_s2  <= csn_s1;
      csn_s3  <= csn_s2;
      sclk_s1 <= SCLK;
      sclk_s2 <= sclk_s1;
      sclk_s3 <= sclk_s2;
      mosi_s1 <= MOSI;
      mosi_s2 <= mosi_s1;
    end
  end

  assign csn_fall  = ~csn_s2 & csn_s3;
  assign csn_rise  = csn_s2 & ~csn_s3;
  assign sclk_rise = sclk_s2 & ~sclk_s3;

  // Frame state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and per-cycle strobes; CSN rise wins over a coincident SCLK rise.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    shift_en  = 1'b0;
    word_done = 1'b0;
    finish    = 1'b0;
    case (state)
      S_IDLE: begin
        if (csn_fall) begin
          start     = 1'b1;
          state_nxt = S_ACT;
        end
      end
      S_ACT: begin
        if (csn_rise) begin
          state_nxt = S_END;
        end else if (sclk_rise) begin
          shift_en  = 1'b1;
          word_done = (bit_cnt == CNT_W'(DATA_W - 1));
        end
      end
      S_END: begin
        finish    = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign frame_done = finish;
  assign bit_err    = finish & (bit_cnt != '0);

  // Shift register, word assembly, word count, CS-high timer and pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_idle     <= 1'b1;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_words <= '0;
      csh_err     <= 1'b0;
      bit_cnt     <= '0;
      shift       <= '0;
      csh_cnt     <= '1;
    end else begin
      rx_valid <= 1'b0;
      csh_err  <= 1'b0;
      if (state == S_IDLE && csh_cnt != '1) csh_cnt <= csh_cnt + SPI0_2'(1);
      if (start) begin
        bit_cnt     <= '0;
        shift       <= '0;
        frame_words <= '0;
        csh_err     <= (csh_cnt < min_csh);
        rx_idle     <= 1'b0;
      end
      if (shift_en) begin
        shift <= {shift[DATA_W-2:0], mosi_s2};
        if (word_done) begin
          bit_cnt  <= '0;
          rx_data  <= {shift[DATA_W-2:0], mosi_s2};
          rx_valid <= 1'b1;
          if (frame_words != 16'hFFFF) frame_words <= frame_words + 16'd1;
        end else begin
          bit_cnt <= bit_cnt + CNT_W'(1);
        end
      end
      if (finish) begin
        csh_cnt <= SPI0_2'(1);
        rx_idle <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_rx_frame.sv
// Testbench for spi_rx_frame: directed and randomized SPI frames checked
// against a word-level reference model of the received stream.
module tb_spi_rx_frame;

  localparam int DW = 8;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CW-1:0] min_csh = 32'd20;
  logic          CSN = 1'b1;
  logic          SCLK = 1'b0;
  logic          MOSI = 1'b0;
  logic          rx_idle;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          frame_done;
  logic [15:0]   frame_words;
  logic          bit_err;
  logic          csh_err;

  spi_rx_frame #(.DATA_W(DW), .SPI0_2(CW)) dut (
    .clk(clk), .rst_n(rst_n), .min_csh(min_csh),
    .CSN(CSN), .SCLK(SCLK), .MOSI(MOSI),
    .rx_idle(rx_idle), .rx_data(rx_data), .rx_valid(rx_valid),
    .frame_done(frame_done), .frame_words(frame_words),
    .bit_err(bit_err), .csh_err(csh_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Output monitor, sampled on the falling edge.
  logic [DW-1:0] rx_log [0:4095];
  int n_rx = 0, done_cnt = 0, be_cnt = 0, csh_seen = 0;
  int fw_done = 0, be_done = 0, valid_cyc = 0;
  always @(negedge clk) begin
    if (rx_valid) begin
      if (n_rx < 4096) rx_log[n_rx] = rx_data;
      n_rx++;
      valid_cyc = cyc;
    end
    if (frame_done) begin
      done_cnt++;
      fw_done = int'(frame_words);
      be_done = int'(bit_err);
    end
    if (bit_err) be_cnt++;
    if (csh_err) csh_seen++;
  end

  int            csn_up_cyc = 0;
  bit            first_after_rst = 1'b1;
  logic [DW-1:0] exp_data = '0;
  int            rise_cyc = 0;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one frame after a CSN-high gap of 'gap' cycles and check it against
  // the model: words are the bit stream chopped into DW-bit MSB-first groups.
  task automatic do_frame(input int nbits, input int gap, input int hp, input bit collide,
                          input bit use_pat, input logic [63:0] pat, input string nm);
    int b0_rx, b0_done, b0_be, b0_csh, h, full, rem;
    bit exp_csh;
    logic bits[$];
    logic b;
    logic [DW-1:0] w;
    b0_rx = n_rx; b0_done = done_cnt; b0_be = be_cnt; b0_csh = csh_seen;
    while (cyc - csn_up_cyc < gap) tick(1);
    h = cyc - csn_up_cyc;
    exp_csh = !first_after_rst && (longint'(h) < longint'(min_csh));
    first_after_rst = 1'b0;
    CSN = 1'b0;
    tick(hp);
    for (int i = 0; i < nbits; i++) begin
      b = use_pat ? pat[nbits-1-i] : 1'($urandom_range(0, 1));
      bits.push_back(b);
      MOSI = b;
      tick(hp);
      SCLK = 1'b1;
      rise_cyc = cyc;
      tick(hp);
      SCLK = 1'b0;
    end
    tick(hp);
    if (collide) begin
      MOSI = 1'($urandom_range(0, 1));
      SCLK = 1'b1;
    end
    CSN = 1'b1;
    csn_up_cyc = cyc;
    tick(6);
    SCLK = 1'b0;
    full = nbits / DW;
    rem  = nbits % DW;
    chk({nm, " words"}, n_rx - b0_rx, full);
    for (int wi = 0; wi < full; wi++) begin
      w = '0;
      for (int k = 0; k < DW; k++) w = (w << 1) | DW'(bits[wi*DW + k]);
      if (b0_rx + wi < n_rx && b0_rx + wi < 4096) chk({nm, " data"}, rx_log[b0_rx + wi], w);
      else chk({nm, " data missing"}, 0, w);
      exp_data = w;
    end
    chk({nm, " done"}, done_cnt - b0_done, 1);
    chk({nm, " frame_words"}, fw_done, (full > 65535) ? 65535 : full);
    chk({nm, " bit_err"}, be_done, (rem != 0) ? 1 : 0);
    chk({nm, " bit_err pulses"}, be_cnt - b0_be, (rem != 0) ? 1 : 0);
    chk({nm, " csh_err"}, csh_seen - b0_csh, exp_csh ? 1 : 0);
    chk({nm, " rx_data held"}, rx_data, exp_data);
    chk({nm, " idle"}, rx_idle, 1);
  endtask

  task automatic chk_reset_outs(input string nm);
    chk({nm, " rx_idle"}, rx_idle, 1);
    chk({nm, " rx_data"}, rx_data, 0);
    chk({nm, " rx_valid"}, rx_valid, 0);
    chk({nm, " frame_done"}, frame_done, 0);
    chk({nm, " frame_words"}, frame_words, 0);
    chk({nm, " bit_err"}, bit_err, 0);
    chk({nm, " csh_err"}, csh_err, 0);
  endtask

  initial begin
    int b0_rx, b0_done, g, nb;
    // Reset with line activity on SCLK/MOSI.
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      SCLK = ~SCLK;
      MOSI = ~MOSI;
    end
    chk_reset_outs("reset");
    SCLK = 1'b0;
    CSN = 1'b1;
    tick(1);
    rst_n = 1'b1;
    csn_up_cyc = cyc;
    first_after_rst = 1'b1;
    tick(5);
    chk("post-reset rx", n_rx, 0);
    chk("post-reset done", done_cnt, 0);
    chk_reset_outs("post-reset");

    // Two words; first frame after reset with a short gap gives no csh_err.
    do_frame(16, 8, 4, 1'b0, 1'b1, 64'hA53C, "a5_3c");
    chk("a5_3c latency", valid_cyc, rise_cyc + 3);
    chk("a5_3c second", rx_data, 8'h3C);

    // Truncated word keeps the previous complete word.
    do_frame(11, 30, 4, 1'b0, 1'b1, 64'h5A7, "trunc");

    // CS-high time check against min_csh=20.
    do_frame(8, 10, 4, 1'b0, 1'b0, 64'h0, "csh_short");
    do_frame(8, 30, 4, 1'b0, 1'b0, 64'h0, "csh_long");

    // CSN rise coincident with an SCLK rise: no shift from that edge.
    do_frame(15, 30, 3, 1'b1, 1'b0, 64'h0, "collide");

    // SCLK/MOSI noise with CSN high.
    b0_rx = n_rx; b0_done = done_cnt;
    for (int i = 0; i < 10; i++) begin
      MOSI = 1'($urandom_range(0, 1));
      SCLK = 1'b1; tick(3);
      SCLK = 1'b0; tick(3);
    end
    tick(4);
    chk("noise rx_valid", n_rx - b0_rx, 0);
    chk("noise frame_done", done_cnt - b0_done, 0);
    do_frame(8, 30, 5, 1'b0, 1'b0, 64'h0, "after_noise");

    // min_csh=0 disables the gap check.
    min_csh = '0;
    do_frame(8, 8, 4, 1'b0, 1'b0, 64'h0, "csh_off");
    min_csh = 32'd20;

    // Reset in the middle of a frame.
    b0_done = done_cnt;
    tick(30);
    CSN = 1'b0;
    tick(4);
    for (int i = 0; i < 5; i++) begin
      MOSI = 1'($urandom_range(0, 1));
      tick(4); SCLK = 1'b1; tick(4); SCLK = 1'b0;
    end
    tick(2);
    rst_n = 1'b0;
    tick(1);
    chk_reset_outs("midreset");
    CSN = 1'b1;
    SCLK = 1'b0;
    tick(2);
    rst_n = 1'b1;
    first_after_rst = 1'b1;
    csn_up_cyc = cyc;
    exp_data = '0;
    tick(6);
    chk("midreset no done", done_cnt - b0_done, 0);
    do_frame(16, 8, 4, 1'b0, 1'b0, 64'h0, "post_midreset");

    // Randomized frames.
    for (int f = 0; f < 20; f++) begin
      nb = $urandom_range(0, 40);
      g = ($urandom_range(0, 1) == 1) ? $urandom_range(8, 16) : $urandom_range(24, 40);
      do_frame(nb, g, $urandom_range(3, 6), 1'($urandom_range(0, 1)), 1'b0, 64'h0, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
